// File: rtl/general_datapath_fsm.sv
// rtl/general_datapath_fsm.sv - accumulator core with fetch/decode/execute controller
//
// Purpose: a parametrised accumulator processor. It has a PC, an instruction register,
// an accumulator A, a 2**AW-word RAM with a synchronous write and an asynchronous read,
// and an add/sub ALU that reports carry and overflow. While the core is idle the host
// writes a program through the prog_* port and then raises run_i.
//
// Ports:
//   clk_i          system clock, rising edge
//   reset_i        synchronous active-high reset (RAM contents are kept)
//   run_i          start/continue execution; sampled at the end of each instruction
//   prog_we_i      program write strobe, honoured only in IDLE
//   prog_addr_i    program write address
//   prog_data_i    program write data
//   data_in_i      operand for IN
//   in_valid_i     data_in_i is valid
//   in_ready_o     core is waiting in INWAIT
//   data_out_o     accumulator A
//   out_valid_o    one-cycle strobe while a STORE executes
//   aeq0_o         A == 0
//   apos_o         A is non-negative
//   cout_o         carry / no-borrow from the last ADD/SUB
//   ovf_o          signed overflow from the last ADD/SUB
//   ir_o           current opcode
//   pc_o           program counter
//   halted_o       core is in HALT
module general_datapath_fsm #(
   parameter int DW = 8,
   parameter int AW = 5
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          run_i,
   input  logic          prog_we_i,
   input  logic [AW-1:0] prog_addr_i,
   input  logic [DW-1:0] prog_data_i,
   input  logic [DW-1:0] data_in_i,
   input  logic          in_valid_i,
   output logic          in_ready_o,
   output logic [DW-1:0] data_out_o,
   output logic          out_valid_o,
   output logic          aeq0_o,
   output logic          apos_o,
   output logic          cout_o,
   output logic          ovf_o,
   output logic [2:0]    ir_o,
   output logic [AW-1:0] pc_o,
   output logic          halted_o
);

   localparam int DEPTH = 1 << AW;

   localparam logic [2:0] OP_LOAD  = 3'd0;
   localparam logic [2:0] OP_STORE = 3'd1;
   localparam logic [2:0] OP_ADD   = 3'd2;
   localparam logic [2:0] OP_SUB   = 3'd3;
   localparam logic [2:0] OP_IN    = 3'd4;
   localparam logic [2:0] OP_JZ    = 3'd5;
   localparam logic [2:0] OP_JPOS  = 3'd6;
   localparam logic [2:0] OP_JMP   = 3'd7;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_INWAIT,
      S_HALT
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [2:0]    op_q, op_d;
   logic [AW-1:0] opa_q, opa_d;
   logic [DW-1:0] a_q, a_d;
   logic          cout_q, cout_d;
   logic          ovf_q, ovf_d;

   logic [DW-1:0] mem_q [DEPTH];
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [DW-1:0] mem_wdata;

   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          is_sub;
   logic [DW-1:0] opnd;
   logic [DW:0]   sum;
   logic          sum_ovf;

   // Only FETCH reads at the PC; every other state addresses the operand.
   assign rd_addr = (state_q == S_FETCH) ? pc_q : opa_q;
   assign rd_data = mem_q[rd_addr];

   // SUB is A + ~M + 1, so the carry out reads as "no borrow".
   assign is_sub  = (op_q == OP_SUB);
   assign opnd    = is_sub ? ~rd_data : rd_data;
   assign sum     = {1'b0, a_q} + {1'b0, opnd} + {{DW{1'b0}}, is_sub};
   assign sum_ovf = (a_q[DW-1] == opnd[DW-1]) && (sum[DW-1] != a_q[DW-1]);

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      op_d        = op_q;
      opa_d       = opa_q;
      a_d         = a_q;
      cout_d      = cout_q;
      ovf_d       = ovf_q;
      mem_we      = 1'b0;
      mem_waddr   = prog_addr_i;
      mem_wdata   = prog_data_i;
      in_ready_o  = 1'b0;
      out_valid_o = 1'b0;
      halted_o    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            mem_we = prog_we_i;
            if (run_i) state_d = S_FETCH;
         end
         S_FETCH: begin
            op_d    = rd_data[DW-1 -: 3];
            opa_d   = rd_data[AW-1:0];
            pc_d    = pc_q + AW'(1);
            state_d = S_DECODE;
         end
         S_DECODE: begin
            if (op_q == OP_IN)                     state_d = S_INWAIT;
            else if (op_q == OP_JMP && (&opa_q))   state_d = S_HALT;
            else                                   state_d = S_EXECUTE;
         end
         S_EXECUTE: begin
            unique case (op_q)
               OP_LOAD:  a_d = rd_data;
               OP_STORE: begin
                  mem_we      = 1'b1;
                  mem_waddr   = opa_q;
                  mem_wdata   = a_q;
                  out_valid_o = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  a_d    = sum[DW-1:0];
                  cout_d = sum[DW];
                  ovf_d  = sum_ovf;
               end
               OP_JZ:   if (a_q == '0)  pc_d = opa_q;
               OP_JPOS: if (!a_q[DW-1]) pc_d = opa_q;
               OP_JMP:  pc_d = opa_q;
               default: ;
            endcase
            state_d = run_i ? S_FETCH : S_IDLE;
         end
         S_INWAIT: begin
            in_ready_o = 1'b1;
            if (in_valid_i) begin
               a_d     = data_in_i;
               state_d = run_i ? S_FETCH : S_IDLE;
            end
         end
         S_HALT: halted_o = 1'b1;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         op_q    <= '0;
         opa_q   <= '0;
         a_q     <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         op_q    <= op_d;
         opa_q   <= opa_d;
         a_q     <= a_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   // RAM is never cleared; reset only blocks a write in the cycle it is asserted.
   always_ff @(posedge clk_i) begin
      if (mem_we && !reset_i) mem_q[mem_waddr] <= mem_wdata;
   end

   assign data_out_o = a_q;
   assign aeq0_o     = (a_q == '0);
   assign apos_o     = ~a_q[DW-1];
   assign cout_o     = cout_q;
   assign ovf_o      = ovf_q;
   assign ir_o       = op_q;
   assign pc_o       = pc_q;

endmodule
